// File: rtl/sig_scan_if.sv
// rtl/sig_scan_if.sv - load stream and scan result bundle for sig_scan
interface sig_scan_if #(
  parameter int NUM_PAT = 8,
  parameter int ADDR_W  = 13,
  parameter int CODE_W  = 4
);
  logic [ADDR_W-1:0]  addr;
  logic               wr;
  logic [7:0]         data;
  logic               done;
  logic [NUM_PAT-1:0] hit;
  logic [CODE_W-1:0]  result;
  logic               result_valid;
  logic               busy;

  modport master (
    output addr, wr, data, done,
    input  hit, result, result_valid, busy
  );

  modport slave (
    input  addr, wr, data, done,
    output hit, result, result_valid, busy
  );
endinterface

// File: rtl/sig_scan.sv
// rtl/sig_scan.sv - masked byte-signature scanner with thresholded, vetoed mapper code resolve
module sig_scan #(
  parameter int NUM_PAT = 8,
  parameter int PAT_LEN = 5,
  parameter int ADDR_W  = 13,
  parameter int CODE_W  = 4,
  parameter logic [NUM_PAT*PAT_LEN*8-1:0] PATTERNS     = '0,
  parameter logic [NUM_PAT*PAT_LEN*8-1:0] MASKS        = '1,
  parameter logic [NUM_PAT*4-1:0]         LENS         = '0,
  parameter logic [NUM_PAT*8-1:0]         NEEDS        = '0,
  parameter logic [NUM_PAT*NUM_PAT-1:0]   VETO         = '0,
  parameter logic [NUM_PAT*CODE_W-1:0]    CODES        = '0,
  parameter logic [CODE_W-1:0]            DEFAULT_CODE = '0
) (
  input logic        clk,
  input logic        reset_n,
  sig_scan_if.slave  bus
);
  localparam int         HW       = (PAT_LEN - 1) * 8;
  localparam logic [3:0] FILL_MAX = 4'(PAT_LEN);

  typedef enum logic [1:0] {IDLE, SCAN, RESOLVE, DONE} state_t;

  state_t              state_q, state_d;
  logic [HW-1:0]       hist_q, hist_d;
  logic [3:0]          fill_q, fill_d;
  logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
  logic [7:0]          count_q [NUM_PAT];
  logic [7:0]          count_d [NUM_PAT];
  logic [CODE_W-1:0]   result_q, result_d;
  logic                rv_q, rv_d;

  logic                restart, contig, accept;
  logic [3:0]          fill_base, fill_new, len_i;
  logic [PAT_LEN*8-1:0] win;
  logic [NUM_PAT-1:0]  match, hit, eligible;
  logic [7:0]          need_i, base_i;
  logic [CODE_W-1:0]   code_sel;

  // win holds the newest byte at [7:0]; older bytes follow at increasing offsets
  always_comb begin
    len_i     = '0;
    win       = {hist_q, bus.data};
    restart   = bus.wr && (bus.addr == '0);
    contig    = (bus.addr == last_addr_q + ADDR_W'(1));
    fill_base = (restart || !contig) ? 4'd0 : fill_q;
    fill_new  = (fill_base >= FILL_MAX) ? FILL_MAX : fill_base + 4'd1;
    match     = '0;
    for (int i = 0; i < NUM_PAT; i++) begin
      len_i    = LENS[i*4 +: 4];
      match[i] = (fill_new >= len_i);
      for (int k = 0; k < PAT_LEN; k++) begin
        if (k < int'(len_i) &&
            (((win[(int'(len_i) - 1 - k)*8 +: 8] ^ PATTERNS[(i*PAT_LEN + k)*8 +: 8])
              & MASKS[(i*PAT_LEN + k)*8 +: 8]) != 8'h00))
          match[i] = 1'b0;
      end
    end
  end

  always_comb begin
    need_i   = '0;
    hit      = '0;
    eligible = '0;
    for (int i = 0; i < NUM_PAT; i++) begin
      need_i = NEEDS[i*8 +: 8];
      hit[i] = count_q[i] >= ((need_i == 8'd0) ? 8'd1 : need_i);
    end
    for (int i = 0; i < NUM_PAT; i++)
      eligible[i] = hit[i] & ~|(hit & VETO[i*NUM_PAT +: NUM_PAT]);
    code_sel = DEFAULT_CODE;
    for (int i = NUM_PAT - 1; i >= 0; i--)
      if (eligible[i]) code_sel = CODES[i*CODE_W +: CODE_W];
  end

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    last_addr_d = last_addr_q;
    count_d     = count_q;
    result_d    = result_q;
    rv_d        = rv_q;
    base_i      = '0;
    accept      = restart || (bus.wr && state_q == SCAN);

    if (accept) begin
      for (int i = 0; i < NUM_PAT; i++) begin
        base_i     = restart ? 8'd0 : count_q[i];
        count_d[i] = (match[i] && base_i != 8'hFF) ? base_i + 8'd1 : base_i;
      end
      hist_d      = win[HW-1:0];
      fill_d      = fill_new;
      last_addr_d = bus.addr;
    end

    case (state_q)
      SCAN:    if (bus.done) state_d = RESOLVE;
      RESOLVE: begin
        result_d = code_sel;
        rv_d     = 1'b1;
        state_d  = DONE;
      end
      default: ;
    endcase

    // a fresh image start overrides everything except a same-cycle done in SCAN
    if (restart) begin
      rv_d = 1'b0;
      if (!(state_q == SCAN && bus.done)) state_d = SCAN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hist_q      <= '0;
      fill_q      <= '0;
      last_addr_q <= '0;
      result_q    <= DEFAULT_CODE;
      rv_q        <= 1'b0;
      for (int i = 0; i < NUM_PAT; i++) count_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      last_addr_q <= last_addr_d;
      result_q    <= result_d;
      rv_q        <= rv_d;
      for (int i = 0; i < NUM_PAT; i++) count_q[i] <= count_d[i];
    end
  end

  assign bus.hit          = hit;
  assign bus.result       = result_q;
  assign bus.result_valid = rv_q;
  assign bus.busy         = (state_q == SCAN);
endmodule

// File: doc/sig_scan.md
# sig_scan

Parametrised byte-signature scanner for cartridge images streamed during ROM load. Watches the load write stream (address, data, strobe) and matches up to NUM_PAT masked byte signatures of configurable length against it. It keeps a saturating hit count per signature and applies per-signature thresholds and veto rules. At end of load it resolves a priority-encoded mapper code. It sits beside the cart loader and feeds the bankswitch-mode select.

## Interface
- NUM_PAT, 8: number of signatures (1..16).
- PAT_LEN, 5: maximum signature length in bytes (2..8).
- ADDR_W, 13: load address width.
- CODE_W, 4: result code width.
- PATTERNS, 0: NUM_PAT*PAT_LEN*8 bits. Signature i is at [i*PAT_LEN*8 +: PAT_LEN*8]; stream byte k (k=0 first) is at [k*8 +: 8] within it.
- MASKS, all 1: same layout as PATTERNS. A 0 bit is don't-care.
- LENS, 0: NUM_PAT*4 bits. Length of signature i is at [i*4 +: 4], range 1..PAT_LEN.
- NEEDS, 0: NUM_PAT*8 bits. Required hit count; a value of 0 is treated as 1.
- VETO, 0: NUM_PAT*NUM_PAT bits. Bit [i*NUM_PAT+j] set means a hit on j suppresses i.
- CODES, 0: NUM_PAT*CODE_W bits. Result code for signature i.
- DEFAULT_CODE, 0: result code when no signature is eligible.
- clk in 1: system clock.
- reset_n in 1: asynchronous, active-low reset.
- addr in ADDR_W: load address of the current byte.
- wr in 1: byte strobe; addr and data are valid when high.
- data in 8: load byte.
- done in 1: one-cycle end-of-load pulse.
- hit out NUM_PAT: live per-signature "count ≥ need" flags.
- result out CODE_W: resolved mapper code.
- result_valid out 1: result is stable.
- busy out 1: high in SCAN state.

## Operation
- States: IDLE, SCAN, RESOLVE, DONE. Reset enters IDLE.
- Any state: wr with addr==0 clears all counts, history, fill and result_valid. That byte is then processed as the first byte, and the block enters SCAN.
- In IDLE or DONE, wr with addr≠0 is ignored.
- In SCAN, each wr is processed against window W = {previous PAT_LEN-1 accepted bytes, data}.
- Contiguity: if addr ≠ last_addr+1, fill resets before the byte is processed; the window restarts at that byte. last_addr wraps modulo 2^ADDR_W.
- fill is a saturating count of contiguous bytes in the window, capped at PAT_LEN.
- Signature i matches when fill (including the current byte) ≥ LEN_i and, for k in 0..LEN_i-1, (W byte k of the last LEN_i bytes XOR PAT_i[k]) & MASK_i[k] == 0.
- Overlapping occurrences each count.
- A match increments count_i (8-bit, saturating at 255). hit[i] = count_i ≥ max(NEED_i,1).
- done in SCAN → RESOLVE.
- In RESOLVE: eligible[i] = hit[i] & ~|(hit & VETO row i). result = CODES of the lowest-index eligible i, else DEFAULT_CODE. Then → DONE with result_valid=1.
- done outside SCAN is ignored.
- If done and wr arrive in the same cycle, the byte is processed first; resolution includes it.
- RESOLVE ignores wr with addr≠0.

## Timing
- Reset values: hit=0, result=DEFAULT_CODE, result_valid=0, busy=0, all counts/fill=0.
- Match and count update are registered on the wr cycle; hit reflects the byte on the next cycle.
- done at cycle t → RESOLVE at t+1 → result/result_valid valid at t+2.
- result_valid is held until the next addr==0 write or reset.
- One byte per clock sustained; no back-pressure.
- reset_n asserted mid-scan aborts immediately to IDLE. No partial result is produced.

## Test plan
Bench configuration, NUM_PAT=4:
- P0: 85 3F, need 2, code 5.
- P1: 8D F9 1F, need 2, code 1.
- P2: 20 00 D0 C6 C5, need 1, code 3, vetoed by P1.
- P3: AD xx 1F (mask 00 on byte 1), need 1, code 12.
- DEFAULT_CODE = 0.

Scenarios:
- Stream 85 3F once at addr 10–11, then done → result=0. Stream it twice → hit[0]=1, result=5 at done+2.
- Stream 20 00 D0 C6 C5 → hit[2]; done → 3. Add two copies of 8D F9 1F → result=1 (P1 wins; P2 vetoed).
- Stream AD 55 1F → result=12 (wildcard). Stream AD 55 1E → 0.
- Stream 85 at addr 20, then 3F at addr 40 (gap), repeated twice → no P0 hit. Stream 85 3F 85 3F contiguous → count_0=2.
- Pattern at addr 0x1FFE–0x1FFF, then done in the same cycle as the last wr → the last byte counts.
- 300 copies of 85 3F → count_0 saturates at 255. Assert reset_n mid-stream → all outputs at reset values, state IDLE. A new addr 0 write restarts the scan.
